// File: rtl/dvp_rgb565_capture.sv
// dvp_rgb565_capture: OV2640 DVP byte stream to RGB565 pixel writes.
// Registers the camera bus, skips settling frames, crops to H_ACT x V_ACT,
// and drives a frame buffer video input (vs_n / de / data).
//
// Optional feature macro: DVP_CAPTURE_TEST_PATTERN_EN
//   When defined, adds I_tp_sel; with I_tp_sel=1 the pixel data is
//   replaced by 8 vertical colour bars (timing and crop unchanged).
//
// Ports:
//   I_clk        camera pixel clock, rising edge
//   I_rst_n      asynchronous active-low reset
//   I_en         capture enable
//   I_vsync      camera VSYNC (active level set by VS_POL)
//   I_href       camera HREF, high during valid line bytes
//   I_data       camera byte (PIXDATA[9:2])
//   I_tp_sel     test pattern select (only with the macro)
//   O_vs_n       active-low frame sync, high outside CAPTURE
//   O_de         one-cycle pixel write strobe
//   O_data       RGB565 pixel {R[4:0],G[5:0],B[4:0]}
//   O_locked     high while capturing
//   O_frame_cnt  captured frame count, wraps
//   O_line_err   sticky short/odd line flag, cleared by I_en=0
module dvp_rgb565_capture #(
    parameter int H_ACT       = 800,
    parameter int V_ACT       = 600,
    parameter int SKIP_FRAMES = 2,
    parameter int VS_POL      = 1
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_en,
    input  logic        I_vsync,
    input  logic        I_href,
    input  logic [7:0]  I_data,
`ifdef DVP_CAPTURE_TEST_PATTERN_EN
    input  logic        I_tp_sel,
`endif
    output logic        O_vs_n,
    output logic        O_de,
    output logic [15:0] O_data,
    output logic        O_locked,
    output logic [7:0]  O_frame_cnt,
    output logic        O_line_err
);

    localparam logic [10:0] H_LIM  = 11'(H_ACT);
    localparam logic [10:0] V_LIM  = 11'(V_ACT);
    localparam logic [3:0]  SKIP_N = 4'(SKIP_FRAMES);
    localparam logic        VS_LVL = 1'(VS_POL);
    localparam logic [10:0] SAT    = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        SKIP    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        vsync_r;
    logic        href_r;
    logic [7:0]  data_r;
    logic        vs_d;
    logic        href_d;

    logic        vs_act;
    logic        fs;
    logic        fe;
    logic        href_fall;
    logic        cap;

    logic [3:0]  skip_cnt;
    logic        phase;
    logic [7:0]  hi_byte;
    logic [10:0] x_cnt;
    logic [10:0] y_cnt;
    logic [15:0] pix;

    // Input stage and one-cycle history for edge detection
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vsync_r <= ~VS_LVL;
            href_r  <= 1'b0;
            data_r  <= 8'd0;
            vs_d    <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            vsync_r <= I_vsync;
            href_r  <= I_href;
            data_r  <= I_data;
            vs_d    <= vs_act;
            href_d  <= href_r;
        end
    end

    assign vs_act    = (vsync_r == VS_LVL);
    assign fs        = vs_act & ~vs_d;
    assign fe        = ~vs_act & vs_d;
    assign href_fall = href_d & ~href_r;
    assign cap       = (state == CAPTURE);

    // FSM: state register
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (I_en) state_next = WAIT_VS;
            end
            WAIT_VS: begin
                if (!I_en)
                    state_next = IDLE;
                else if (fs)
                    state_next = (SKIP_N != 4'd0) ? SKIP : CAPTURE;
            end
            SKIP: begin
                if (!I_en)
                    state_next = IDLE;
                else if (fs && skip_cnt <= 4'd1)
                    state_next = CAPTURE;
            end
            CAPTURE: begin
                // the current frame always completes before leaving
                if (!I_en && fe) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        O_locked = (state == CAPTURE);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            skip_cnt <= 4'd0;
        end else if (state == IDLE) begin
            skip_cnt <= 4'd0;
        end else if (fs && state == WAIT_VS) begin
            skip_cnt <= SKIP_N;
        end else if (fs && state == SKIP) begin
            skip_cnt <= skip_cnt - 4'd1;
        end
    end

    // Byte pairing and line/column counters. A frame start drops any
    // half-assembled pixel and restarts the counts.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            phase   <= 1'b0;
            hi_byte <= 8'd0;
            x_cnt   <= 11'd0;
            y_cnt   <= 11'd0;
        end else if (fs) begin
            phase <= 1'b0;
            x_cnt <= 11'd0;
            y_cnt <= 11'd0;
        end else begin
            if (href_r) begin
                phase <= ~phase;
                if (!phase)
                    hi_byte <= data_r;
                else if (x_cnt != SAT)
                    x_cnt <= x_cnt + 11'd1;
            end else begin
                phase <= 1'b0;
            end
            if (href_fall) begin
                x_cnt <= 11'd0;
                if (y_cnt != SAT) y_cnt <= y_cnt + 11'd1;
            end
        end
    end

`ifdef DVP_CAPTURE_TEST_PATTERN_EN
    localparam logic [10:0] BAR_W = 11'(H_ACT / 8);

    logic [10:0] bar_idx;
    logic [15:0] bar_rgb;

    assign bar_idx = x_cnt / BAR_W;

    always_comb begin
        bar_rgb = 16'h0000;
        case (bar_idx)
            11'd0:   bar_rgb = 16'hFFFF;
            11'd1:   bar_rgb = 16'hFFE0;
            11'd2:   bar_rgb = 16'h07FF;
            11'd3:   bar_rgb = 16'h07E0;
            11'd4:   bar_rgb = 16'hF81F;
            11'd5:   bar_rgb = 16'hF800;
            11'd6:   bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase
    end

    assign pix = I_tp_sel ? bar_rgb : {hi_byte, data_r};
`else
    assign pix = {hi_byte, data_r};
`endif

    // Output stage; x_cnt is the index of the pixel completing now
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_de   <= 1'b0;
            O_data <= 16'd0;
            O_vs_n <= 1'b1;
        end else begin
            O_de <= 1'b0;
            if (cap && href_r && phase && !fs &&
                x_cnt < H_LIM && y_cnt < V_LIM) begin
                O_de   <= 1'b1;
                O_data <= pix;
            end
            // next state so the sync edge lines up with the first frame
            O_vs_n <= (state_next == CAPTURE) ? ~vs_act : 1'b1;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_frame_cnt <= 8'd0;
        end else if (cap && fe) begin
            O_frame_cnt <= O_frame_cnt + 8'd1;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_line_err <= 1'b0;
        end else if (!I_en) begin
            O_line_err <= 1'b0;
        end else if (cap && href_fall && y_cnt < V_LIM &&
                     (phase || x_cnt < H_LIM)) begin
            O_line_err <= 1'b1;
        end
    end

endmodule

// File: doc/dvp_rgb565_capture.md
Name: dvp_rgb565_capture

Overview:
- Camera-side capture stage, directly upstream of the video frame buffer write port.
- Samples the OV2640 DVP bus (VSYNC, HREF, 8-bit byte stream) in the camera pixel-clock domain and pairs bytes into RGB565 pixels.
- Skips settling frames, crops to the buffer's active window and reports line errors.
- Outputs feed the frame buffer's vin0 vs_n / de / data inputs directly, with one write strobe per pixel.

Parameters:
- H_ACT, 800: pixels per line passed downstream; wider lines are cropped.
- V_ACT, 600: lines per frame passed downstream; extra lines are dropped.
- SKIP_FRAMES, 2: complete frames discarded after enable before capture starts (range 0..15).
- VS_POL, 1: I_vsync active level (1 = active high).

Ports:
- I_clk  in  1  camera pixel clock (PIXCLK); all logic is on the rising edge.
- I_rst_n  in  1  asynchronous active-low reset.
- I_en  in  1  capture enable.
- I_vsync  in  1  camera VSYNC.
- I_href  in  1  camera HREF; high during valid line bytes.
- I_data  in  8  camera byte, which is PIXDATA[9:2].
- O_vs_n  out  1  active-low frame sync to the frame buffer.
- O_de  out  1  one-cycle pixel write strobe.
- O_data  out  16  RGB565 pixel, {R[4:0],G[5:0],B[4:0]}.
- O_locked  out  1  high while in CAPTURE.
- O_frame_cnt  out  8  count of captured frames.
- O_line_err  out  1  sticky short/odd-line flag.

Behaviour:
- Clock and reset:
  - Single clock I_clk. Reset is asynchronous, active-low on I_rst_n.
  - Reset values: O_vs_n=1, O_de=0, O_data=0, O_locked=0, O_frame_cnt=0, O_line_err=0, FSM=IDLE, all counters 0.
- Input stage:
  - I_vsync, I_href and I_data are registered once.
  - All decisions use the registered copies. vs_act = (vsync_r == VS_POL).
- Frame edges:
  - Frame start = rising edge of vs_act.
  - Frame end = falling edge of vs_act.
- FSM:
  - IDLE: stays while I_en=0. Goes to WAIT_VS when I_en=1.
  - WAIT_VS: waits for a frame start. Loads skip_cnt=SKIP_FRAMES. Goes to SKIP if SKIP_FRAMES>0, else to CAPTURE.
  - SKIP: decrements skip_cnt on each frame start. Goes to CAPTURE on the frame start where skip_cnt reaches 0. The frame that starts at that edge is the first frame captured.
  - CAPTURE: passes pixels downstream. If I_en=0, goes to IDLE on the next frame end, so the current frame always completes. If I_en returns to 1 before that frame end, the FSM stays in CAPTURE.
- Byte pairing (CAPTURE only):
  - Phase bit toggles on every cycle with href_r=1. Phase clears whenever href_r=0.
  - Phase 0 byte is latched as the high byte. The phase 1 byte completes the pixel.
  - O_data = {high, low}. O_de pulses for 1 cycle.
  - Latency: O_de rises exactly 2 I_clk edges after the edge that presented the low byte on I_data.
- Counters:
  - x_cnt (11b) counts completed pixels in the line. It clears on the href_r falling edge.
  - y_cnt (11b) increments on each href_r falling edge. It clears on frame start.
- Crop:
  - O_de is asserted only when x_cnt < H_ACT and y_cnt < V_ACT.
  - Otherwise the pixel is dropped and O_data holds its last value.
  - Counters saturate at 2047; they do not wrap.
- O_vs_n:
  - Equals ~vs_act, delayed to align with the data path, while in CAPTURE.
  - Held at 1 in all other states, so the frame buffer never sees a partial-frame sync.
- O_frame_cnt: increments on each frame end in CAPTURE. Wraps 255 -> 0.
- O_line_err:
  - Set when an href_r falling edge in CAPTURE, with y_cnt < V_ACT, has phase=1 (odd byte count) or x_cnt < H_ACT (short line).
  - Stays set until I_en=0 or reset.
- Simultaneous events:
  - href_r high during vs_act in CAPTURE: bytes are processed normally.
  - Frame start while a line is in progress: y_cnt clears and the partial pixel is discarded.

Optional Feature:
- Macro: DVP_CAPTURE_TEST_PATTERN_EN.
- When defined:
  - Adds input I_tp_sel (1b).
  - When I_tp_sel=1, O_data is replaced by 8 vertical colour bars, 100 px wide for H_ACT=800. Bar index = x_cnt[10:0]/(H_ACT/8).
  - Bar colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Timing, strobes and crop are unchanged.
- When not defined: no I_tp_sel port, and O_data always carries camera data.

Test Plan:
- Reset mid-CAPTURE with O_de pulsing -> all outputs return to reset values within the same cycle; FSM=IDLE.
- I_en=1, SKIP_FRAMES=2, three 800x600 frames of bytes 0x12,0x34 -> first two frames produce no O_de. Third frame produces 480000 O_de pulses with O_data=16'h1234. O_frame_cnt=1, O_locked=1.
- Line of 1000 pixels (2000 bytes) in CAPTURE -> exactly 800 O_de pulses on that line; O_line_err stays 0.
- Line of 1601 bytes -> 800 pixels output; O_line_err=1 after the href fall. Then I_en=0 -> O_line_err clears.
- I_en deasserted mid-frame -> pixels continue to frame end, O_vs_n returns high, FSM=IDLE. Next frames produce no O_de.
- Macro defined, I_tp_sel=1 -> pixel x=0 gives FFFF, x=150 gives FFE0, x=799 gives 0000.
